// File: rtl/io_responder.sv
// io_responder: memory-mapped scratch RAM plus interval timer with an intr/int_ack handshake
module io_responder #(
  parameter int ADDR_W    = 12,
  parameter int RAM_WORDS = 960
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [31:0] ALU_OUT,
  input  logic [31:0] D_OUT,
  input  logic        int_ack,
  output logic [31:0] DY,
  output logic        intr
);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  localparam logic [ADDR_W-1:0] A_RAM_END = ADDR_W'(RAM_WORDS * 4);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(32'hF00);
  localparam logic [ADDR_W-1:0] A_PERIOD  = ADDR_W'(32'hF04);
  localparam logic [ADDR_W-1:0] A_COUNT   = ADDR_W'(32'hF08);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(32'hF0C);
  localparam logic [ADDR_W-1:0] A_ICNT    = ADDR_W'(32'hF10);

  logic [31:0]       ram [RAM_WORDS];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-3:0] idx;
  logic              wr, rd, in_ram;
  logic              ctrl_wr, period_wr, status_wr, icnt_wr;
  logic              en, auto_rl;
  logic [31:0]       period, count, icnt, rdata;
  logic              tick, expire, ack, missed;
  state_t            state;
  logic              unused_bits;

  // Byte address bits below the word and above the decoded window play no part in decoding.
  assign unused_bits = ^{ALU_OUT[31:ADDR_W], ALU_OUT[1:0]};
  assign idx         = ALU_OUT[ADDR_W-1:2];
  assign addr        = {idx, 2'b00};
  assign wr          = io_cs & io_wr;
  assign rd          = io_cs & io_rd;
  assign in_ram      = addr < A_RAM_END;
  assign ctrl_wr     = wr & (addr == A_CTRL);
  assign period_wr   = wr & (addr == A_PERIOD);
  assign status_wr   = wr & (addr == A_STATUS);
  assign icnt_wr     = wr & (addr == A_ICNT);
  assign tick        = en & (count == 32'd1);
  assign expire      = tick | (ctrl_wr & D_OUT[2]);
  assign ack         = (state == REQ) & int_ack;
  assign intr        = (state == REQ);

  // Scratch RAM: write-only port here, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr & in_ram) ram[idx] <= D_OUT;
  end

  // Interval timer: CTRL write with EN reloads COUNT; expiry either reloads (AUTO) or stops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      period  <= '0;
      count   <= '0;
    end else begin
      if (period_wr) period <= D_OUT;
      en      <= ctrl_wr ? D_OUT[0] : en & ~(tick & ~auto_rl);
      auto_rl <= ctrl_wr ? D_OUT[1] : auto_rl;
      count   <= (ctrl_wr & D_OUT[0]) ? period :
                 !en                  ? count :
                 (count > 32'd1)      ? count - 32'd1 :
                 (tick & auto_rl)     ? period : 32'd0;
    end
  end

  // Interrupt handshake: an expire outside IDLE is dropped and recorded as MISSED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      missed <= 1'b0;
      icnt   <= '0;
    end else begin
      state  <= (state == IDLE) ? (expire ? REQ : IDLE) :
                (state == REQ)  ? (int_ack ? ACK : REQ) :
                                  (int_ack ? ACK : IDLE);
      missed <= (expire & (state != IDLE)) | (missed & ~(status_wr & D_OUT[2]));
      icnt   <= ack ? (icnt_wr ? 32'd1 : icnt + 32'd1) : icnt_wr ? 32'd0 : icnt;
    end
  end

  // Combinational read mux; unmapped register space reads zero.
  always_comb begin
    rdata = in_ram                 ? ram[idx] :
            (addr == A_CTRL)       ? {30'd0, auto_rl, en} :
            (addr == A_PERIOD)     ? period :
            (addr == A_COUNT)      ? count :
            (addr == A_STATUS)     ? {29'd0, missed, state == ACK, state == REQ} :
            (addr == A_ICNT)       ? icnt : 32'd0;
  end

  assign DY = rd ? rdata : 32'hz;
endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
Memory-mapped I/O responder on the far side of the CPU's io_cs/io_wr/io_rd bus.
- Returns read data on DY and accepts write data from D_OUT, addressed by ALU_OUT.
- Holds a word-addressed scratch RAM and a programmable interval timer.
- The timer raises intr toward the MCU and completes the intr/int_ack handshake.

Parameters:
ADDR_W, 12, I/O address bits decoded from ALU_OUT[ADDR_W-1:0]
RAM_WORDS, 960, scratch RAM depth in 32-bit words, mapped at 0x000–0xEFF

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
io_cs  input  1  I/O chip select from MCU
io_wr  input  1  write strobe, qualified by io_cs
io_rd  input  1  read strobe, qualified by io_cs
ALU_OUT  input  32  byte address; [1:0] ignored (word aligned)
D_OUT  input  32  write data
int_ack  input  1  interrupt acknowledge from MCU
DY  output  32  read data; 32'hz when not (io_cs & io_rd)
intr  output  1  interrupt request to MCU, registered

Behaviour:
Address map, using addr = ALU_OUT[ADDR_W-1:0]:
- 0x000–0xEFF: RAM, word index addr[ADDR_W-1:2]; RW.
- 0xF00 CTRL:
  - bit0 EN
  - bit1 AUTO
  - bit2 FORCE: write-only, self-clearing, always reads 0
  - other bits read 0
- 0xF04 PERIOD: 32-bit, RW.
- 0xF08 COUNT: read-only; writes ignored.
- 0xF0C STATUS:
  - bit0 REQ: intr state
  - bit1 INSVC: FSM in ACK
  - bit2 MISSED: sticky; write 1 to clear
- 0xF10 ICNT: 32-bit count of acknowledged interrupts; write any value clears to 0.
- Unmapped 0xF14–0xFFF: reads 0, writes ignored.

Access timing:
- Reads are combinational: DY is valid in the same cycle as io_cs & io_rd.
- Writes commit on the rising clk edge where io_cs & io_wr.
- io_wr and io_rd high together: the write commits at the edge; DY shows the pre-edge value.

Reset (reset low, asynchronous):
- intr=0; CTRL=0; PERIOD=0; COUNT=0; MISSED=0; ICNT=0; FSM=IDLE.
- RAM contents are undefined and not reset.

Timer:
- A write to CTRL with bit0=1 loads COUNT<=PERIOD.
- Each edge while EN=1 and COUNT>1: COUNT<=COUNT-1.
- Edge with EN=1 and COUNT==1 produces one expire event:
  - AUTO=1: COUNT<=PERIOD.
  - AUTO=0: COUNT<=0 and EN<=0.
- PERIOD=0 with EN=1: COUNT stays 0; no expire ever occurs.
- EN=0 freezes COUNT.
- Writing FORCE=1 generates an expire event at that edge, independent of EN and COUNT.
- Net latency: intr rises on the edge P cycles after the edge that wrote EN=1, PERIOD=P. With AUTO=1, expires repeat every P cycles.

Interrupt FSM (registered; intr = (state==REQ)):
- IDLE: expire -> REQ.
- REQ: int_ack=1 -> ACK (intr falls on the same edge) and ICNT<=ICNT+1. ICNT wraps 0xFFFFFFFF -> 0.
- ACK: int_ack=0 -> IDLE. While int_ack stays high, remain in ACK.
- An expire while in REQ or ACK is not queued: it sets MISSED=1 and the state is unchanged.
- Same-edge software clear of MISSED plus a missed expire: the set wins (MISSED=1).
- Same-edge ICNT clear write plus acknowledge: ICNT=1.
- int_ack asserted in IDLE is ignored.
- Reset asserted mid-handshake returns to IDLE with intr=0 immediately, without waiting for a clock edge.

Test Plan:
1. Reset low with intr forced busy, then release -> intr=0, reads at 0xF00/0xF04/0xF08/0xF0C/0xF10 all return 0; DY=32'hz with io_cs=0.
2. Write 0xDEADBEEF to 0x010 and 0x12345678 to 0x014, then read both back -> same values; read 0xF14 -> 0; write to 0xF08 -> COUNT unchanged.
3. PERIOD=5, CTRL=0x1 -> intr rises exactly 5 cycles after the CTRL write edge; EN reads 0 afterwards; hold int_ack 2 cycles -> intr falls on the first ack edge, STATUS=0x2 during ACK, ICNT=1, back to IDLE after int_ack drops.
4. PERIOD=3, CTRL=0x3, never acknowledge -> intr stays high, MISSED=1 after the second expire; write STATUS=0x4 while expires continue -> MISSED re-sets on the next expire.
5. CTRL=0x4 with EN=0 -> intr high the next cycle, COUNT unaffected; then PERIOD=0, CTRL=0x1 -> no interrupt within 100 cycles.
6. Drive reset low while in ACK with int_ack high -> intr=0 and state IDLE asynchronously; after release, int_ack high alone does not change ICNT.
